// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for a ROWS x COLS output-stationary systolic array. An accepted
// start issues K operand reads, launches a skewed enable/clear wavefront into
// column 0 of every row and strobes the capture of each anti-diagonal in the
// single cycle its results are valid.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   i_start      start request (sampled in IDLE only)
//   i_k_len      reduction length K, latched with an accepted start
//   i_abort      synchronous abort of the running tile
//   o_busy       tile in progress (cycle 1 through the done cycle)
//   o_rd_en      operand read request to the A/B skew buffers
//   o_rd_k       reduction index of the current read
//   o_row_en     per-row enable into column 0
//   o_row_clear  per-row accumulator clear into column 0
//   o_cap_valid  result capture strobe
//   o_cap_diag   anti-diagonal index being captured
//   o_done       one-cycle tile-complete pulse
// ---------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int K_WIDTH  = 8,
    parameter int MULT_LAT = 1,
    parameter int DIAG_W   = $clog2(ROWS + COLS - 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [K_WIDTH-1:0]  i_k_len,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_rd_en,
    output logic [K_WIDTH-1:0]  o_rd_k,
    output logic [ROWS-1:0]     o_row_en,
    output logic [ROWS-1:0]     o_row_clear,
    output logic                o_cap_valid,
    output logic [DIAG_W-1:0]   o_cap_diag,
    output logic                o_done
);

    // Cycle counter is wide enough that K = 2^K_WIDTH-1 plus the drain tail never wraps.
    localparam int CW = K_WIDTH + $clog2(ROWS + COLS + MULT_LAT) + 1;
    localparam logic [CW-1:0] TAIL_LEN  = CW'(MULT_LAT + ROWS + COLS);
    localparam logic [CW-1:0] CAP_OFS   = CW'(MULT_LAT + 2);
    localparam logic [CW-1:0] E0_END_OF = CW'(MULT_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [K_WIDTH-1:0] r_k;
    logic [K_WIDTH-1:0] w_k_nxt;
    logic               w_active;

    logic [CW-1:0]      w_r_k_ext;
    logic [CW-1:0]      w_r_done_cyc;
    logic [CW-1:0]      w_k_ext;
    logic [CW-1:0]      w_done_cyc;
    logic [CW-1:0]      w_cap_first;

    logic               w_rd_en_nxt;
    logic [K_WIDTH-1:0] w_rd_k_nxt;
    logic [ROWS-1:0]    w_row_en_nxt;
    logic [ROWS-1:0]    w_row_clear_nxt;
    logic               w_cap_nxt;
    logic [DIAG_W-1:0]  w_diag_nxt;
    logic               w_done_nxt;

    assign w_r_k_ext    = {{(CW-K_WIDTH){1'b0}}, r_k};
    assign w_r_done_cyc = w_r_k_ext + TAIL_LEN;
    assign w_k_ext      = {{(CW-K_WIDTH){1'b0}}, w_k_nxt};
    assign w_done_cyc   = w_k_ext + TAIL_LEN;
    assign w_cap_first  = w_k_ext + CAP_OFS;

    // Next-state logic: w_cnt_nxt is the tile cycle number shown after the coming edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_active    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && (i_k_len != {K_WIDTH{1'b0}})) begin
                    w_state_nxt = S_FEED;
                    w_cnt_nxt   = CW'(1);
                    w_k_nxt     = i_k_len;
                    w_active    = 1'b1;
                end else begin
                    w_cnt_nxt   = {CW{1'b0}};
                end
            end
            S_FEED: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_active    = 1'b1;
                    if (r_cnt == w_r_k_ext) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_FEED;
                    end
                end
            end
            S_DRAIN: begin
                // The done cycle is still busy; IDLE begins on the edge after it.
                if (i_abort || (r_cnt == w_r_done_cyc)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_active    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode for the coming cycle; row enables/clears shift one row per cycle.
    always_comb begin
        w_rd_en_nxt     = 1'b0;
        w_rd_k_nxt      = {K_WIDTH{1'b0}};
        w_row_en_nxt    = {ROWS{1'b0}};
        w_row_clear_nxt = {ROWS{1'b0}};
        w_cap_nxt       = 1'b0;
        w_diag_nxt      = {DIAG_W{1'b0}};
        w_done_nxt      = 1'b0;
        if (w_active) begin
            w_rd_en_nxt = (w_cnt_nxt >= CW'(1)) && (w_cnt_nxt <= w_k_ext);
            if (w_rd_en_nxt) begin
                w_rd_k_nxt = K_WIDTH'(w_cnt_nxt - CW'(1));
            end else begin
                w_rd_k_nxt = o_rd_k;
            end
            // e0: read enable delayed by the buffer latency, stretched by MULT_LAT.
            w_row_en_nxt[0]    = (w_cnt_nxt >= CW'(2)) && (w_cnt_nxt <= (w_k_ext + E0_END_OF));
            w_row_clear_nxt[0] = (w_cnt_nxt == CW'(2));
            for (int r = 1; r < ROWS; r++) begin
                w_row_en_nxt[r]    = o_row_en[r-1];
                w_row_clear_nxt[r] = o_row_clear[r-1];
            end
            w_cap_nxt = (w_cnt_nxt >= w_cap_first) && (w_cnt_nxt <= w_done_cyc);
            if (w_cap_nxt) begin
                w_diag_nxt = DIAG_W'(w_cnt_nxt - w_cap_first);
            end else begin
                w_diag_nxt = {DIAG_W{1'b0}};
            end
            w_done_nxt = (w_cnt_nxt == w_done_cyc);
        end else begin
            w_rd_en_nxt = 1'b0;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_k         <= {K_WIDTH{1'b0}};
            o_busy      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_k      <= {K_WIDTH{1'b0}};
            o_row_en    <= {ROWS{1'b0}};
            o_row_clear <= {ROWS{1'b0}};
            o_cap_valid <= 1'b0;
            o_cap_diag  <= {DIAG_W{1'b0}};
            o_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_k         <= w_k_nxt;
            o_busy      <= w_active;
            o_rd_en     <= w_rd_en_nxt;
            o_rd_k      <= w_rd_k_nxt;
            o_row_en    <= w_row_en_nxt;
            o_row_clear <= w_row_clear_nxt;
            o_cap_valid <= w_cap_nxt;
            o_cap_diag  <= w_diag_nxt;
            o_done      <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl
// Self-checking bench for systolic_ctrl. Cycle N output values are those seen
// during clock period N; an input "at cycle N" is sampled at the end of it.
// The reference model tracks only "tile running, cycle n, length K" and
// derives every output from the timing formulas of the sequencer.
// ---------------------------------------------------------------------------
module tb_systolic_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int K_WIDTH  = 8;
    localparam int MULT_LAT = 1;
    localparam int DIAG_W   = $clog2(ROWS + COLS - 1);
    localparam int VW       = 3 + K_WIDTH + 2 * ROWS + DIAG_W + 1;

    logic               clk;
    logic               rst_n;
    logic               i_start;
    logic [K_WIDTH-1:0] i_k_len;
    logic               i_abort;
    logic               o_busy;
    logic               o_rd_en;
    logic [K_WIDTH-1:0] o_rd_k;
    logic [ROWS-1:0]    o_row_en;
    logic [ROWS-1:0]    o_row_clear;
    logic               o_cap_valid;
    logic [DIAG_W-1:0]  o_cap_diag;
    logic               o_done;

    systolic_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .K_WIDTH(K_WIDTH), .MULT_LAT(MULT_LAT), .DIAG_W(DIAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len), .i_abort(i_abort),
        .o_busy(o_busy), .o_rd_en(o_rd_en), .o_rd_k(o_rd_k), .o_row_en(o_row_en),
        .o_row_clear(o_row_clear), .o_cap_valid(o_cap_valid), .o_cap_diag(o_cap_diag),
        .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {o_busy, o_rd_en, o_rd_k, o_row_en, o_row_clear, o_cap_valid, o_cap_diag, o_done};

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    bit m_act = 1'b0;
    int m_n   = 0;
    int m_k   = 0;

    function automatic int done_cycle(int k);
        return k + MULT_LAT + ROWS + COLS;
    endfunction

    // Expected outputs for tile cycle n of a length-k tile.
    function automatic logic [VW-1:0] model_vec(bit act, int n, int k);
        logic               busy, rd_en, cap, done;
        logic [K_WIDTH-1:0] rd_k;
        logic [ROWS-1:0]    ren, rclr;
        logic [DIAG_W-1:0]  diag;
        int                 cap0;
        busy = 1'b0; rd_en = 1'b0; cap = 1'b0; done = 1'b0;
        rd_k = '0; ren = '0; rclr = '0; diag = '0;
        if (act) begin
            cap0  = k + 2 + MULT_LAT;
            busy  = 1'b1;
            rd_en = (n >= 1) && (n <= k);
            rd_k  = K_WIDTH'((n <= k) ? n - 1 : k - 1);
            for (int r = 0; r < ROWS; r++) begin
                ren[r]  = ((n - r) >= 2) && ((n - r) <= k + 1 + MULT_LAT);
                rclr[r] = ((n - r) == 2);
            end
            cap  = (n >= cap0) && (n <= done_cycle(k));
            diag = cap ? DIAG_W'(n - cap0) : '0;
            done = (n == done_cycle(k));
        end
        return {busy, rd_en, rd_k, ren, rclr, cap, diag, done};
    endfunction

    // Advance one clock; the model consumes the same sampled inputs as the DUT.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (i_abort || m_n == done_cycle(m_k)) m_act = 1'b0;
            else m_n++;
        end else if (i_start && i_k_len != 0) begin
            m_act = 1'b1;
            m_n   = 1;
            m_k   = int'(i_k_len);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_start = 1'b0;
        i_abort = 1'b0;
        i_k_len = '0;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b1; i_k_len = 8'd5; i_abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dut_vec !== '0) begin
                n_errors++;
                $display("FAIL reset cyc=%0d got=%h exp=0", i, dut_vec);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_k8();
        int dones = 0;
        cyc = 0;
        i_start = 1'b1; i_k_len = 8'd8;
        step();
        idle_inputs();
        while (cyc <= 20) begin
            n_checks++;
            if (dut_vec !== model_vec(m_act, m_n, m_k)) begin
                n_errors++;
                $display("FAIL k8_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec(m_act, m_n, m_k));
            end
            n_checks++;
            if (o_row_clear[3] !== (cyc == 5)) begin
                n_errors++;
                $display("FAIL k8_clear3 cyc=%0d got=%b", cyc, o_row_clear[3]);
            end
            n_checks++;
            if (o_busy !== (cyc >= 1 && cyc <= 17)) begin
                n_errors++;
                $display("FAIL k8_busy cyc=%0d got=%b", cyc, o_busy);
            end
            if (cyc == 17) begin
                n_checks++;
                if (o_done !== 1'b1 || o_cap_diag !== 3'd6) begin
                    n_errors++;
                    $display("FAIL k8_done cyc=17 got done=%b diag=%0d exp done=1 diag=6", o_done, o_cap_diag);
                end
            end
            if (cyc == 8) begin
                n_checks++;
                if (o_rd_k !== 8'd7 || o_rd_en !== 1'b1) begin
                    n_errors++;
                    $display("FAIL k8_lastread got en=%b k=%0d exp en=1 k=7", o_rd_en, o_rd_k);
                end
            end
            if (o_done === 1'b1) dones++;
            step();
        end
        n_checks++;
        if (dones != 1) begin
            n_errors++;
            $display("FAIL k8_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_k1();
        cyc = 0;
        i_start = 1'b1; i_k_len = 8'd1;
        step();
        idle_inputs();
        while (cyc <= 12) begin
            n_checks++;
            if (dut_vec !== model_vec(m_act, m_n, m_k)) begin
                n_errors++;
                $display("FAIL k1_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec(m_act, m_n, m_k));
            end
            n_checks++;
            if (o_row_en[0] !== (cyc == 2 || cyc == 3) || o_done !== (cyc == 10)) begin
                n_errors++;
                $display("FAIL k1_window cyc=%0d got row_en0=%b done=%b", cyc, o_row_en[0], o_done);
            end
            step();
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        cyc = 0;
        i_start = 1'b1; i_k_len = 8'd8;
        step();
        idle_inputs();
        while (cyc <= 35) begin
            n_checks++;
            if (dut_vec !== model_vec(m_act, m_n, m_k)) begin
                n_errors++;
                $display("FAIL ign_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec(m_act, m_n, m_k));
            end
            if (cyc == 18 || cyc == 19) begin
                n_checks++;
                if (o_rd_en !== (cyc == 19) || o_rd_k !== 8'd0) begin
                    n_errors++;
                    $display("FAIL ign_restart cyc=%0d got rd_en=%b rd_k=%0d", cyc, o_rd_en, o_rd_k);
                end
            end
            if (o_done === 1'b1) dones++;
            idle_inputs();
            if (cyc == 5 || cyc == 17) begin i_start = 1'b1; i_k_len = 8'd3; end
            if (cyc == 18) begin i_start = 1'b1; i_k_len = 8'd4; end
            step();
        end
        n_checks++;
        if (dones != 2) begin
            n_errors++;
            $display("FAIL ign_done_count got=%0d exp=2", dones);
        end
    endtask

    task automatic test_k0();
        cyc = 0;
        i_start = 1'b1; i_k_len = 8'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (dut_vec !== '0) begin
                n_errors++;
                $display("FAIL k0 cyc=%0d got=%h exp=0", cyc, dut_vec);
            end
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        int dones = 0;
        cyc = 0;
        i_start = 1'b1; i_k_len = 8'd8;
        step();
        idle_inputs();
        while (cyc <= 22) begin
            n_checks++;
            if (dut_vec !== model_vec(m_act, m_n, m_k)) begin
                n_errors++;
                $display("FAIL abort_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec(m_act, m_n, m_k));
            end
            if (cyc == 7) begin
                n_checks++;
                if (dut_vec !== '0) begin
                    n_errors++;
                    $display("FAIL abort_clear cyc=7 got=%h exp=0", dut_vec);
                end
            end
            if (o_done === 1'b1) dones++;
            idle_inputs();
            if (cyc == 6) i_abort = 1'b1;
            if (cyc == 7) begin i_start = 1'b1; i_k_len = 8'd2; i_abort = 1'b1; end
            step();
        end
        n_checks++;
        if (dones != 1) begin
            n_errors++;
            $display("FAIL abort_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        cyc = 0;
        i_start = 1'b1; i_k_len = 8'd8;
        step();
        idle_inputs();
        while (cyc <= 20) begin
            n_checks++;
            if (dut_vec !== model_vec(m_act, m_n, m_k)) begin
                n_errors++;
                $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec(m_act, m_n, m_k));
            end
            if (cyc >= 13) begin
                n_checks++;
                if (dut_vec !== '0) begin
                    n_errors++;
                    $display("FAIL rstmid_clear cyc=%0d got=%h exp=0", cyc, dut_vec);
                end
            end
            if (o_done === 1'b1) dones++;
            idle_inputs();
            if (cyc == 12) rst_n = 1'b0;
            step();
        end
        n_checks++;
        if (dones != 0) begin
            n_errors++;
            $display("FAIL rstmid_done_count got=%0d exp=0", dones);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst_n   = ($urandom_range(0, 599) != 0);
            i_start = ($urandom_range(0, 5) == 0);
            i_k_len = ($urandom_range(0, 15) == 0) ? K_WIDTH'($urandom_range(240, 255))
                                                   : K_WIDTH'($urandom_range(0, 12));
            i_abort = ($urandom_range(0, 79) == 0);
            step();
            n_checks++;
            if (dut_vec !== model_vec(m_act, m_n, m_k)) begin
                n_errors++;
                $display("FAIL random it=%0d got=%h exp=%h", i, dut_vec, model_vec(m_act, m_n, m_k));
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_k8();
        test_k1();
        test_start_ignored();
        test_k0();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for a ROWS x COLS output-stationary systolic array of `systolic_pe` cells. On each start, `systolic_ctrl` does four things: it issues K read requests to the operand skew buffers, drives a per-row skewed enable/clear pair into column 0 of each row, tracks the wavefront through the array, and strobes the capture of each anti-diagonal's accumulated results during the single cycle they are valid. It sits between the tile scheduler (start/length/abort) and the array plus its edge buffers and result collector.

## Interface
- ROWS, 4: array rows.
- COLS, 4: array columns.
- K_WIDTH, 8: width of reduction length and read index.
- MULT_LAT, 1: PE multiplier latency in cycles.
- DIAG_W, $clog2(ROWS+COLS-1): capture diagonal index width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- i_start  in  1  start request, sampled only in IDLE.
- i_k_len  in  K_WIDTH  reduction length K, latched with accepted start.
- i_abort  in  1  synchronous abort of the running tile.
- o_busy  out  1  tile in progress.
- o_rd_en  out  1  operand read request to A/B skew buffers.
- o_rd_k  out  K_WIDTH  reduction index of the current read.
- o_row_en  out  ROWS  per-row `i_spe_en` into column 0.
- o_row_clear  out  ROWS  per-row `i_mult_clear` into column 0.
- o_cap_valid  out  1  result capture strobe.
- o_cap_diag  out  DIAG_W  anti-diagonal d=r+c being captured.
- o_done  out  1  one-cycle tile-complete pulse.

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE → FEED: on i_start=1 with i_k_len≠0. i_k_len is latched on that edge, called cycle 0.
- i_start with i_k_len=0 is ignored: no busy, no done.
- FEED runs K cycles, cycles 1..K.
  - o_rd_en=1 throughout; o_rd_k=0..K-1, incrementing by 1.
  - Then → DRAIN.
- DRAIN: a counter runs until the done cycle, then → IDLE.
- Base enable e0:
  - e0 = o_rd_en delayed 1 cycle, which is the buffer read latency, stretched by MULT_LAT extra cycles.
  - e0 is high during cycles 2..K+1+MULT_LAT.
- o_row_en[r] = e0 delayed r cycles, implemented as a shift register.
- o_row_clear[r] = first-cycle pulse of e0, delayed r cycles.
- Each PE forwards its enable rightward with a 1-cycle delay, so PE(r,c) enable window is cycles 2+r+c .. K+1+MULT_LAT+r+c.
- PE(r,c) result is valid only at cycle K+2+MULT_LAT+r+c, because the PE zeroes its sum when enable drops.
- Capture strobes:
  - o_cap_valid=1 for cycles K+2+MULT_LAT .. K+MULT_LAT+ROWS+COLS.
  - o_cap_diag counts 0..ROWS+COLS-2 across those cycles.
- o_done=1 together with the last capture, at cycle K+MULT_LAT+ROWS+COLS.
- o_busy=1 from cycle 1 through the done cycle inclusive.
- i_start while busy is ignored; it is not queued.
- The earliest next start is sampled in the cycle after o_done.
- i_abort while busy:
  - Next edge: → IDLE.
  - All enable/clear shift registers, o_rd_en, o_cap_valid and o_busy clear.
  - No o_done is issued.
  - i_abort in IDLE has no effect.
  - If i_abort and i_start arrive in the same cycle in IDLE, start is accepted.
- Counters are K_WIDTH+$clog2(ROWS+COLS+MULT_LAT)+1 bits wide, so there is no wrap at K=2^K_WIDTH-1.

## Timing
- Every output is a register; none are combinational from inputs.
- Reset values: o_busy=0, o_rd_en=0, o_rd_k=0, o_row_en=0, o_row_clear=0, o_cap_valid=0, o_cap_diag=0, o_done=0; state IDLE.
- rst_n low mid-tile has the same effect as reset from any state: all outputs take reset values on the next edge, and no done is issued.
- Start-to-first-read latency: 1 cycle.
- Start-to-done latency: K+MULT_LAT+ROWS+COLS cycles.
- o_rd_k holds its last value (K-1) after FEED and returns to 0 in IDLE.
- o_cap_diag is 0 whenever o_cap_valid=0.

## Test plan
- ROWS=COLS=4, MULT_LAT=1, K=8, start at cycle 0 → o_rd_en cycles 1-8 with o_rd_k 0-7; o_row_en[0] cycles 2-10; o_row_en[3] cycles 5-13; o_row_clear[3] only at cycle 5; o_cap_valid cycles 11-17 with diag 0-6; o_done at cycle 17; o_busy cycles 1-17.
- K=1, same array → single read at cycle 1; o_row_en[0] cycles 2-3; captures at cycles 4-10; o_done at 10.
- Start at cycle 0 (K=8), i_start again at cycles 5 and 17 → both ignored; start at cycle 18 accepted; its first read is at cycle 19.
- i_k_len=0 with i_start → o_busy stays 0, no reads, no done.
- i_abort at cycle 6 of a K=8 tile → cycle 7: all outputs 0, state IDLE; no o_done ever; a new start at cycle 7 is accepted.
- rst_n=0 at cycle 12 of a K=8 tile → all outputs at reset values from the edge at cycle 12; no further captures or done.
